// File: rtl/mac_result_drain_pkg.sv
// Shared definitions for the matmul result drain stage.
//   - default datapath widths (DWIDTH, NUM_MACS, AWIDTH)
//   - 2-bit drain FSM state encoding
//   - helper that maps a programmed tile count of 0 to 1
package mac_result_drain_pkg;

    localparam int DWIDTH_DEF   = 16;
    localparam int NUM_MACS_DEF = 4;
    localparam int AWIDTH_DEF   = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A programmed count of zero still writes one row.
    function automatic logic [7:0] tiles_or_one(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Output-matrix memory write port.
//   wr_valid / wr_addr / wr_data : request from the drain (master)
//   wr_ready                     : memory accepts when wr_valid & wr_ready
interface mac_result_drain_if
    import mac_result_drain_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int WWIDTH = NUM_MACS_DEF * DWIDTH_DEF
);
    logic              wr_valid;
    logic [AWIDTH-1:0] wr_addr;
    logic [WWIDTH-1:0] wr_data;
    logic              wr_ready;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/mac_result_drain_drain_fifo.sv
// Synchronous FIFO buffering captured result rows.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous flush
//   push, din  : write a row (ignored when full unless popping the same cycle)
//   pop        : remove head (ignored when empty)
//   dout       : current head
//   full/empty : occupancy flags
module drain_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               rptr, wptr;
    logic [PW:0]                 cnt;
    logic                        do_push, do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot being written (wptr == rptr).
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mac_result_drain.sv
// Result drain for a row of NUM_MACS seq_mac instances.
// Tracks each tile's acc_last through a LATENCY-deep token line, captures
// mac_out when the token exits, buffers rows in a FIFO and writes them to
// memory at base_addr + k*stride. done pulses after num_tiles writes.
//   clk, reset                 : clock, synchronous active-high reset
//   start, base_addr, stride,
//   num_tiles                  : run setup (start honoured only when idle)
//   acc_last, mac_out          : seq_mac row tile-end marker and results
//   wr                         : memory write port (master)
//   busy, done, overflow       : status
module mac_result_drain
    import mac_result_drain_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int NUM_MACS   = NUM_MACS_DEF,
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [AWIDTH-1:0]          base_addr,
    input  logic [AWIDTH-1:0]          stride,
    input  logic [7:0]                 num_tiles,
    input  logic                       acc_last,
    input  logic [NUM_MACS*DWIDTH-1:0] mac_out,
    mac_result_drain_if.master         wr,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);
    localparam int WW = NUM_MACS * DWIDTH;

    logic [1:0]         state;
    logic [AWIDTH-1:0]  addr_q, stride_q;
    logic [7:0]         remaining;
    logic [LATENCY-1:0] tok;
    logic               run, capture, pop, push, drop;
    logic               full, empty;
    logic [WW-1:0]      head;

    assign run     = (state == ST_RUN);
    assign capture = run & tok[LATENCY-1];

    // Gated by reset so nothing is issued in the cycle reset is asserted.
    assign wr.wr_valid = run & ~empty & ~reset;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = wr.wr_valid ? head : '0;

    assign pop  = wr.wr_valid & wr.wr_ready;
    assign push = capture & (~full | pop);
    assign drop = capture & full & ~pop;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    drain_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_DONE),
        .push  (push),
        .pop   (pop),
        .din   (mac_out),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            stride_q  <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
            tok       <= '0;
        end else begin
            // Tokens only live while running; leaving RUN discards them.
            tok <= run ? ((tok << 1) | LATENCY'(acc_last)) : '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        addr_q    <= base_addr;
                        stride_q  <= stride;
                        remaining <= tiles_or_one(num_tiles);
                        overflow  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (drop) overflow <= 1'b1;
                    if (pop) begin
                        addr_q    <= addr_q + stride_q;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;
    localparam int L  = 5;
    localparam int D  = 4;
    localparam int AW = 10;
    localparam int W  = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [7:0]    num_tiles = '0;
    logic          acc_last = 1'b0;
    logic [W-1:0]  mac_out = '0;
    logic          ready = 1'b0;
    logic          busy, done, overflow;

    mac_result_drain_if #(.AWIDTH(AW), .WWIDTH(W)) wr_bus ();
    assign wr_bus.wr_ready = ready;

    mac_result_drain #(.DWIDTH(16), .NUM_MACS(4), .AWIDTH(AW), .LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
        .num_tiles(num_tiles), .acc_last(acc_last), .mac_out(mac_out), .wr(wr_bus),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_run = 0, m_done = 0, m_ovf = 0;
    logic [AW-1:0] m_addr = '0, m_stride = '0;
    int            m_rem = 0;
    logic [W-1:0]  fq[$];            // buffered rows, head first
    int            tq[$];            // cycle at which each pending tile is captured
    int            cyc = 0;
    logic [AW-1:0] log_a[$];
    logic [W-1:0]  log_d[$];
    int            log_c[$];
    int            done_cnt = 0;
    bit            exp_valid;

    always begin
        @(negedge clk);
        exp_valid = m_run && fq.size() > 0 && !reset;
        chk("wr_valid", W'(wr_bus.wr_valid), W'(exp_valid));
        chk("wr_addr", W'(wr_bus.wr_addr), W'(m_addr));
        if (exp_valid) chk("wr_data", wr_bus.wr_data, fq[0]);
        chk("busy", W'(busy), W'(m_run || m_done));
        chk("done", W'(done), W'(m_done));
        chk("overflow", W'(overflow), W'(m_ovf));
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_done = 0; m_ovf = 0; m_addr = '0; m_stride = '0; m_rem = 0;
            fq.delete(); tq.delete();
        end else if (m_done) begin
            m_done = 0; fq.delete(); tq.delete();
        end else if (m_run) begin
            bit cap, acc;
            cap = tq.size() > 0 && tq[0] == cyc;
            if (cap) void'(tq.pop_front());
            acc = exp_valid && ready;
            if (acc) begin
                log_a.push_back(m_addr); log_d.push_back(fq[0]); log_c.push_back(cyc);
                void'(fq.pop_front());
                m_addr = m_addr + m_stride;
                m_rem--;
            end
            if (cap) begin
                if (fq.size() < D) fq.push_back(mac_out);
                else m_ovf = 1;
            end
            if (acc_last) tq.push_back(cyc + L);
            if (acc && m_rem == 0) begin
                m_run = 0; m_done = 1; done_cnt++; tq.delete();
            end
        end else if (start) begin
            m_run = 1; m_addr = base_addr; m_stride = stride;
            m_rem = (num_tiles == 0) ? 1 : int'(num_tiles); m_ovf = 0;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit st, input bit a, input logic [W-1:0] mo, input bit r);
        start = st; acc_last = a; mac_out = mo; ready = r;
        @(posedge clk); #1;
        start = 0;
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] pat(input int k);
        logic [15:0] b;
        b = 16'hA000 + 16'(k);
        return {b + 16'h0300, b + 16'h0200, b + 16'h0100, b};
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_run || m_done) && n < budget) begin
            tick(0, 0, rnd64(), 1);
            n++;
        end
        checks++;
        if (m_run || m_done) begin
            errors++;
            $display("FAIL wait_idle timeout after %0d cycles expected idle", budget);
        end
    endtask

    task automatic clear_log();
        log_a.delete(); log_d.delete(); log_c.delete();
    endtask

    task automatic setup(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [7:0] n);
        base_addr = b; stride = s; num_tiles = n;
    endtask

    initial begin
        int d0;
        repeat (3) tick(0, 0, '0, 0);
        reset = 0;
        chk("rst wr_valid", W'(wr_bus.wr_valid), '0);
        chk("rst wr_addr", W'(wr_bus.wr_addr), '0);
        chk("rst wr_data", wr_bus.wr_data, '0);
        chk("rst busy", W'(busy), '0);
        chk("rst done", W'(done), '0);
        chk("rst overflow", W'(overflow), '0);

        // Basic row
        clear_log(); d0 = done_cnt;
        setup(10'h010, 10'd4, 8'd1);
        tick(1, 0, rnd64(), 1);
        tick(0, 1, rnd64(), 1);
        repeat (L - 1) tick(0, 0, rnd64(), 1);
        tick(0, 0, 64'h0004_0003_0002_0001, 1);
        wait_idle(20);
        chk("basic count", W'(log_a.size()), W'(1));
        if (log_a.size() == 1) begin
            chk("basic addr", W'(log_a[0]), W'(10'h010));
            chk("basic data", log_d[0], 64'h0004_0003_0002_0001);
        end
        chk("basic done", W'(done_cnt - d0), W'(1));

        // Stream with an ignored start mid-run
        clear_log(); d0 = done_cnt;
        setup(10'h010, 10'd4, 8'd4);
        tick(1, 0, rnd64(), 1);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) setup(10'h200, 10'd1, 8'd9);
            tick(i == 2, i < 4, (i >= L && i < L + 4) ? pat(i - L) : rnd64(), 1);
        end
        wait_idle(20);
        chk("stream count", W'(log_a.size()), W'(4));
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            chk("stream addr", W'(log_a[i]), W'(10'h010 + 4 * i));
            chk("stream data", log_d[i], pat(i));
            chk("stream cycle", W'(log_c[i]), W'(log_c[0] + i));
        end
        chk("stream done", W'(done_cnt - d0), W'(1));

        // Backpressure / overflow
        clear_log(); d0 = done_cnt;
        setup(10'h010, 10'd4, 8'd4);
        tick(1, 0, rnd64(), 0);
        for (int i = 0; i < 14; i++)
            tick(0, i < 5, (i >= L && i < L + 5) ? pat(i - L) : rnd64(), 0);
        chk("ovf sticky", W'(overflow), W'(1));
        wait_idle(20);
        chk("ovf count", W'(log_a.size()), W'(4));
        for (int i = 0; i < 4 && i < log_d.size(); i++)
            chk("ovf data", log_d[i], pat(i));

        // Address wrap
        clear_log();
        setup(10'h3FE, 10'd3, 8'd2);
        tick(1, 0, rnd64(), 1);
        tick(0, 1, rnd64(), 1);
        tick(0, 1, rnd64(), 1);
        wait_idle(30);
        chk("wrap count", W'(log_a.size()), W'(2));
        if (log_a.size() == 2) begin
            chk("wrap addr0", W'(log_a[0]), W'(10'h3FE));
            chk("wrap addr1", W'(log_a[1]), W'(10'h001));
        end

        // Stalled writes with toggling ready
        clear_log();
        setup(10'h040, 10'd8, 8'd3);
        tick(1, 0, rnd64(), 0);
        for (int i = 0; i < 30; i++) tick(0, i < 3, rnd64(), 1'($urandom_range(0, 1)));
        wait_idle(30);
        chk("stall count", W'(log_a.size()), W'(3));

        // Reset mid-run with two rows buffered
        clear_log(); d0 = done_cnt;
        setup(10'h080, 10'd1, 8'd4);
        tick(1, 0, rnd64(), 0);
        for (int i = 0; i < 10; i++) tick(0, i < 2, rnd64(), 0);
        reset = 1;
        tick(0, 0, rnd64(), 1);
        reset = 0;
        chk("rstrun wr_valid", W'(wr_bus.wr_valid), '0);
        chk("rstrun busy", W'(busy), '0);
        tick(0, 0, rnd64(), 1);
        chk("rstrun log", W'(log_a.size()), '0);
        chk("rstrun no done", W'(done_cnt - d0), '0);
        setup(10'h010, 10'd4, 8'd1);
        tick(1, 0, rnd64(), 1);
        tick(0, 1, rnd64(), 1);
        repeat (L - 1) tick(0, 0, rnd64(), 1);
        tick(0, 0, 64'h0004_0003_0002_0001, 1);
        wait_idle(20);
        chk("fresh count", W'(log_a.size()), W'(1));
        if (log_a.size() == 1) begin
            chk("fresh addr", W'(log_a[0]), W'(10'h010));
            chk("fresh data", log_d[0], 64'h0004_0003_0002_0001);
        end

        // acc_last in IDLE is ignored; num_tiles=0 writes one row
        clear_log(); d0 = done_cnt;
        for (int i = 0; i < 8; i++) tick(0, 1, rnd64(), 1);
        chk("idle acc log", W'(log_a.size()), '0);
        setup(10'h123, 10'd5, 8'd0);
        tick(1, 1, rnd64(), 1);
        repeat (8) tick(0, 0, rnd64(), 1);
        chk("idle acc no write", W'(log_a.size()), '0);
        tick(0, 1, rnd64(), 1);
        wait_idle(20);
        chk("zero tiles count", W'(log_a.size()), W'(1));
        chk("zero tiles done", W'(done_cnt - d0), W'(1));

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            int n = 0;
            setup(AW'($urandom), AW'($urandom), 8'($urandom_range(0, 6)));
            tick(1, 0, rnd64(), 1'($urandom_range(0, 1)));
            while ((m_run || m_done) && n < 400) begin
                tick(0, $urandom_range(0, 9) < 4, rnd64(), $urandom_range(0, 9) < 7);
                n++;
            end
            repeat (3) tick(0, 1'($urandom_range(0, 1)), rnd64(), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
- Downstream stage of a row of NUM_MACS seq_mac instances.
- Tracks when each accumulated tile result appears on the seq_mac outputs and captures the packed row of saturated DWIDTH results into a small FIFO.
- Drains captured rows to the output-matrix memory write port with valid/ready handshake and strided address generation.
- Signals done after the programmed number of tiles has been written.

Parameters:
- DWIDTH, 16, width of one seq_mac result.
- NUM_MACS, 4, seq_mac instances per row; write word is NUM_MACS*DWIDTH bits.
- AWIDTH, 10, memory address width.
- LATENCY, 5, cycles from acc_last (with final operands at seq_mac inputs) to that result being stable on mac_out.
- FIFO_DEPTH, 4, captured rows buffered; power of two, >=2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; latches base_addr, stride, num_tiles; ignored unless IDLE.
- base_addr  input  AWIDTH  address of first row written.
- stride  input  AWIDTH  address increment per row.
- num_tiles  input  8  rows to write; 0 treated as 1.
- acc_last  input  1  final operand of a tile is presented to the seq_mac row this cycle.
- mac_out  input  NUM_MACS*DWIDTH  packed seq_mac outputs; MAC i in bits [i*DWIDTH +: DWIDTH].
- wr_valid  output  1  write request.
- wr_addr  output  AWIDTH  write address.
- wr_data  output  NUM_MACS*DWIDTH  write data.
- wr_ready  input  1  memory accepts the write when wr_valid & wr_ready.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at completion.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.

Behaviour:
- Reset values: wr_valid 0, wr_addr 0, wr_data 0, busy 0, done 0, overflow 0. FIFO is emptied, the token delay line is cleared, counters are 0, and state is IDLE.
- Reset mid-operation aborts immediately; no write is issued in the reset cycle or in the cycle after it.
- States:
  - IDLE: start -> RUN. Load addr_q=base_addr, stride_q=stride, remaining=max(num_tiles,1). Clear overflow.
  - RUN: captures and drains rows. When the accepted write that makes remaining==0 occurs -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Token delay line: a LATENCY-deep shift register of 1-bit tokens. Input bit is acc_last & (state==RUN). Back-to-back acc_last pulses are tracked independently, one token per tile.
- Capture: when a token exits the line (cycle t+LATENCY for acc_last at t), mac_out in that same cycle is pushed into the FIFO.
- Full FIFO at capture: the push is dropped and overflow is set. Exception: if a pop also occurs that cycle, the push succeeds.
- Push into an empty FIFO: no bypass; wr_valid rises the following cycle.
- Write port:
  - wr_valid = FIFO non-empty & state==RUN.
  - wr_data = FIFO head; wr_addr = addr_q.
  - Both stay stable while wr_valid & !wr_ready.
  - On accept: pop; addr_q <= addr_q + stride_q modulo 2^AWIDTH (wraps silently); remaining decrements.
- Tokens still in flight when RUN is left are discarded, and rows left in the FIFO are flushed on the exit to IDLE. acc_last in IDLE or DONE creates no token.
- start while busy is ignored.
- Data is stored unmodified; saturation is already applied upstream.
- Throughput: one row written per cycle when wr_ready is held high.

Decomposition:
- Shared package holds:
  - DWIDTH, AWIDTH, NUM_MACS defaults, consistent with the rest of the matmul datapath.
  - The 2-bit state encoding: IDLE=0, RUN=1, DONE=2.
- Sub-module drain_fifo: synchronous FIFO.
  - Parameters: width NUM_MACS*DWIDTH, depth FIFO_DEPTH.
  - Ports: push, pop, din, dout (head), full, empty; plus a sync clear used on the exit to IDLE.
  - Supports simultaneous push/pop when full.
- Top level holds the FSM, token delay line, address and tile counters.

Test Plan:
- Basic row: start with base=0x010, stride=4, num_tiles=1; acc_last at cycle 10; mac_out=0x0004_0003_0002_0001 at cycle 15; wr_ready=1 -> wr_valid at cycle 16 with addr 0x010 and that data, then done pulses at cycle 17 and busy drops at cycle 18.
- Stream: num_tiles=4, acc_last on 4 consecutive cycles, wr_ready=1 -> 4 writes at addresses 0x010, 0x014, 0x018, 0x01C on consecutive cycles, each carrying the mac_out sampled LATENCY cycles after its acc_last; single done pulse.
- Backpressure/overflow: wr_ready=0, 5 consecutive acc_last -> 4 rows captured and overflow=1. Release wr_ready -> the first 4 rows are written in order and the fifth is absent.
- Address wrap: base=0x3FE, stride=3, num_tiles=2 -> write addresses 0x3FE, then 0x001.
- Stalled write and reset: wr_ready toggling 0/1 -> wr_addr/wr_data stay stable while stalled. Reset asserted in RUN with 2 rows buffered -> wr_valid=0 the next cycle, busy=0, no done, and a following start behaves like a fresh run.
- Ignored inputs: acc_last in IDLE and start while busy -> no writes and no parameter reload; num_tiles=0 -> exactly one write, then done.
